// File: rtl/load_store_unit.sv
// Data-memory access stage: issues one request/acknowledge bus transaction per load/store.
// Latency: 3 cycles with a zero-wait ack (IDLE, REQ, DONE); each bus wait adds one REQ cycle.
// Backpressure: stall is held while a transaction is outstanding; a missing ack aborts after TIMEOUT REQ cycles.
//
// Ports:
//   clk, rst_n              core clock, asynchronous active-low reset
//   memRead, memWrite       decoded load/store controls (memRead wins when both are high)
//   funct3, addr, storeData access size/sign, effective address, rs2 operand
//   memData                 registered, extended load result
//   stall, misaligned       combinational pipeline freeze and access-fault flags
//   busError                one-cycle pulse when the bus times out
//   mem_req/we/addr/wdata/be registered bus request side
//   mem_ack, mem_rdata      bus completion and read word

module load_store_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic [31:0] memData,
  output logic        stall,
  output logic        misaligned,
  output logic        busError,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic [31:0] memData_q;
  logic        busError_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;
  // Load shape captured at issue, since the core's inputs are not trusted during REQ.
  logic        ld_q;
  logic [2:0]  ld_f3_q;
  logic [1:0]  ld_off_q;

  logic        is_rd;
  logic        is_wr;
  logic        access;
  logic        legal;
  logic        aligned;
  logic        start;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] ld_ext_d;
  logic [7:0]  cnt_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Read has priority: a store control alongside a load is ignored.
  assign is_rd  = memRead;
  assign is_wr  = memWrite & ~memRead;
  assign access = memRead | memWrite;

  always_comb begin
    legal = 1'b0;
    if (is_rd) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end else if (is_wr) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end
  end

  // funct3[1:0] encodes the access size for every legal code.
  always_comb begin
    case (funct3[1:0])
      2'b01:   aligned = ~addr[0];
      2'b10:   aligned = (addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign start      = access & legal & aligned;
  assign misaligned = (state_q == IDLE) & access & ~(legal & aligned);
  assign stall      = ((state_q == IDLE) & start) | (state_q == REQ);

  // Store lane placement; sub-word data is replicated so the slave can pick any lane.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = storeData;
    if (is_wr) begin
      case (funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << addr[1:0];
          wdata_d = {4{storeData[7:0]}};
        end
        2'b01: begin
          be_d    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{storeData[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = storeData;
        end
      endcase
    end
  end

  // Load alignment and extension from the captured offset/size.
  always_comb begin
    ld_byte = mem_rdata[{ld_off_q, 3'b000} +: 8];
    ld_half = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_f3_q)
      3'b000:  ld_ext_d = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext_d = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext_d = {24'd0, ld_byte};
      3'b101:  ld_ext_d = {16'd0, ld_half};
      default: ld_ext_d = mem_rdata;
    endcase
  end

  assign cnt_d = cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      memData_q   <= 32'd0;
      busError_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      ld_q        <= 1'b0;
      ld_f3_q     <= 3'd0;
      ld_off_q    <= 2'd0;
    end else begin
      busError_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= is_wr;
            mem_addr_q  <= {addr[31:2], 2'b00};
            mem_be_q    <= be_d;
            mem_wdata_q <= wdata_d;
            ld_q        <= is_rd;
            ld_f3_q     <= funct3;
            ld_off_q    <= addr[1:0];
            cnt_q       <= 8'd0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // An ack in the same cycle as the counter expiring still completes the access.
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (ld_q) begin
              memData_q <= ld_ext_d;
            end
            state_q <= DONE;
          end else if (cnt_d == TIMEOUT_C) begin
            mem_req_q  <= 1'b0;
            busError_q <= 1'b1;
            cnt_q      <= cnt_d;
            state_q    <= ERR;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        ERR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign memData   = memData_q;
  assign busError  = busError_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule
